// File: rtl/demux32_deserializer.sv
// Bit-serial to word deserializer: inverse of the 32:1 bit-select mux.
// Next word assembles while the previous one waits for the consumer.
module demux32_deserializer #(
  parameter int N         = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [N-1:0]  acc;
  logic [N-1:0]  merged;
  logic [IW-1:0] pos;
  logic          last;
  logic          accept;
  logic          complete;
  logic          consume;

  assign last     = (index == LAST);
  assign pos      = MSB_FIRST ? (LAST - index) : index;

  // Stall only when the final bit would overwrite an unconsumed word.
  assign in_ready = !(last && out_valid && !out_ready);

  assign accept   = in_valid && in_ready;
  assign complete = accept && last;
  assign consume  = out_valid && out_ready;

  // Word with the incoming bit already in place, so completion has no bubble.
  always_comb begin
    merged      = acc;
    merged[pos] = in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      acc       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc   <= merged;
        index <= last ? '0 : index + IW'(1);
      end
      if (complete) begin
        out       <= merged;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
